mem_arbiter: RTL and testbench

Two-requester arbiter sharing the core's single unified memory port between instruction fetch and data load/store. Sits between the fetch unit, the load/store path (driven by `mem_write`/`write_back_source` decode) and the external memory. Serialises one access at a time with request/grant/valid handshakes, favours data over fetch with bounded starvation, and optionally aborts hung accesses.

---
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and memory-side handshakes around mem_arbiter.
// slave: the arbiter's view. master: the fetch/LSU/memory environment's view.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Fetch requester
    logic                    i_req;
    logic [ADDR_WIDTH-1:0]   i_addr;
    logic                    i_gnt;
    logic                    i_rvalid;
    logic [DATA_WIDTH-1:0]   i_rdata;
    logic                    i_err;
    // Data requester
    logic                    d_req;
    logic                    d_we;
    logic [ADDR_WIDTH-1:0]   d_addr;
    logic [DATA_WIDTH-1:0]   d_wdata;
    logic [DATA_WIDTH/8-1:0] d_be;
    logic                    d_gnt;
    logic                    d_rvalid;
    logic [DATA_WIDTH-1:0]   d_rdata;
    logic                    d_err;
    // Shared memory port
    logic                    m_req;
    logic                    m_we;
    logic [ADDR_WIDTH-1:0]   m_addr;
    logic [DATA_WIDTH-1:0]   m_wdata;
    logic [DATA_WIDTH/8-1:0] m_be;
    logic                    m_ack;
    logic [DATA_WIDTH-1:0]   m_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata, i_err,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output m_req, m_we, m_addr, m_wdata, m_be,
        input  m_ack, m_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata, i_err,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  m_req, m_we, m_addr, m_wdata, m_be,
        output m_ack, m_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for the single unified memory port, one access at a time.
// Ports: clk, rst (sync, active-high), bus (mem_arbiter_if.slave):
//   i_*  fetch req/gnt/rvalid/rdata/err, d_* data req/gnt/rvalid/rdata/err,
//   m_*  memory req/we/addr/wdata/be with m_ack/m_rdata completion.
// Data wins ties, but after MAX_D_BURST data grants with fetch waiting,
// fetch wins. Optional hung-access abort: define MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_D_BURST    = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int BW       = $clog2(MAX_D_BURST + 1);

    if (MAX_D_BURST < 1) begin : g_bad_burst
        $error("MAX_D_BURST must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t                state;
    logic [BW-1:0]         burst_cnt;
    logic                  fetch_due;
    logic                  sel_d;
    logic                  sel_i;

    logic                  m_req_q;
    logic                  m_we_q;
    logic [ADDR_WIDTH-1:0] m_addr_q;
    logic [DATA_WIDTH-1:0] m_wdata_q;
    logic [BE_WIDTH-1:0]   m_be_q;
    logic                  i_rvalid_q;
    logic [DATA_WIDTH-1:0] i_rdata_q;
    logic                  d_rvalid_q;
    logic [DATA_WIDTH-1:0] d_rdata_q;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TW-1:0]         tmo_cnt;
    logic                  i_err_q;
    logic                  d_err_q;
`endif

    // Fetch has waited through a full data burst and must go next.
    assign fetch_due = (burst_cnt == BW'(MAX_D_BURST));
    assign sel_d     = (state == IDLE) && bus.d_req &&
                       !(bus.i_req && fetch_due);
    assign sel_i     = (state == IDLE) && bus.i_req && !sel_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_be_q     <= '0;
            i_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rvalid_q <= 1'b0;
            d_rdata_q  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_cnt    <= '0;
            i_err_q    <= 1'b0;
            d_err_q    <= 1'b0;
`endif
        end else begin
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (sel_d) begin
                        state     <= BUSY_D;
                        m_req_q   <= 1'b1;
                        m_we_q    <= bus.d_we;
                        m_addr_q  <= bus.d_addr;
                        m_wdata_q <= bus.d_wdata;
                        m_be_q    <= bus.d_be;
                        // Only grants that make fetch wait count.
                        if (!bus.i_req)
                            burst_cnt <= '0;
                        else if (!fetch_due)
                            burst_cnt <= burst_cnt + 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                        tmo_cnt   <= '0;
`endif
                    end else if (sel_i) begin
                        state     <= BUSY_I;
                        m_req_q   <= 1'b1;
                        m_we_q    <= 1'b0;
                        m_addr_q  <= bus.i_addr;
                        m_wdata_q <= '0;
                        m_be_q    <= '1;
                        burst_cnt <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
                        tmo_cnt   <= '0;
`endif
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (bus.m_ack) begin
                        state   <= IDLE;
                        m_req_q <= 1'b0;
                        if (state == BUSY_I) begin
                            i_rvalid_q <= 1'b1;
                            i_rdata_q  <= bus.m_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
                            i_err_q    <= 1'b0;
`endif
                        end else begin
                            d_rvalid_q <= 1'b1;
                            d_rdata_q  <= m_we_q ? '0 : bus.m_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
                            d_err_q    <= 1'b0;
`endif
                        end
`ifdef MEM_ARB_TIMEOUT_EN
                    // Counter holds BUSY cycles already spent, so this
                    // edge ends cycle number TIMEOUT_CYCLES.
                    end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state   <= IDLE;
                        m_req_q <= 1'b0;
                        if (state == BUSY_I) begin
                            i_rvalid_q <= 1'b1;
                            i_rdata_q  <= '0;
                            i_err_q    <= 1'b1;
                        end else begin
                            d_rvalid_q <= 1'b1;
                            d_rdata_q  <= '0;
                            d_err_q    <= 1'b1;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.i_gnt    = sel_i;
    assign bus.d_gnt    = sel_d;
    assign bus.m_req    = m_req_q;
    assign bus.m_we     = m_we_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_wdata  = m_wdata_q;
    assign bus.m_be     = m_be_q;
    assign bus.i_rvalid = i_rvalid_q;
    assign bus.i_rdata  = i_rdata_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.d_rdata  = d_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    assign bus.i_err    = i_err_q;
    assign bus.d_err    = d_err_q;
`else
    assign bus.i_err    = 1'b0;
    assign bus.d_err    = 1'b0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXB = 4;
    localparam int TMO  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_D_BURST(MAXB),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.d_be    = '0;
        bus.m_ack   = 1'b0;
        bus.m_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Random-phase model state
    int          busy, burst, bcyc, win, win_prev, ng, cnt;
    logic        exp_irv, exp_drv, exp_ierr, exp_derr;
    logic [31:0] last_ird, last_drd, rd;
    logic        cur_we;
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_be;
    byte         order[10];

    initial begin
        // Reset state
        do_reset();
        settle();
        check("rst_i_gnt", bus.i_gnt, 0);
        check("rst_d_gnt", bus.d_gnt, 0);
        check("rst_i_rvalid", bus.i_rvalid, 0);
        check("rst_d_rvalid", bus.d_rvalid, 0);
        check("rst_i_rdata", bus.i_rdata, 0);
        check("rst_d_rdata", bus.d_rdata, 0);
        check("rst_i_err", bus.i_err, 0);
        check("rst_d_err", bus.d_err, 0);
        check("rst_m_req", bus.m_req, 0);
        check("rst_m_we", bus.m_we, 0);
        check("rst_m_addr", bus.m_addr, 0);
        check("rst_m_wdata", bus.m_wdata, 0);
        check("rst_m_be", bus.m_be, 0);

        // Lone fetch
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h100;
        settle();
        check("lone_i_gnt", bus.i_gnt, 1);
        check("lone_d_gnt", bus.d_gnt, 0);
        next_cycle();
        bus.i_req   = 1'b0;
        bus.m_ack   = 1'b1;
        bus.m_rdata = 32'h13;
        settle();
        check("lone_m_req", bus.m_req, 1);
        check("lone_m_addr", bus.m_addr, 32'h100);
        check("lone_m_we", bus.m_we, 0);
        check("lone_m_be", bus.m_be, 4'hF);
        check("lone_rv_early", bus.i_rvalid, 0);
        next_cycle();
        bus.m_ack = 1'b0;
        settle();
        check("lone_i_rvalid", bus.i_rvalid, 1);
        check("lone_i_rdata", bus.i_rdata, 32'h13);
        check("lone_i_err", bus.i_err, 0);
        check("lone_m_req_off", bus.m_req, 0);
        next_cycle();
        settle();
        check("lone_rv_pulse", bus.i_rvalid, 0);
        check("lone_rdata_hold", bus.i_rdata, 32'h13);

        // Simultaneous requests, data write first
        do_reset();
        bus.i_req   = 1'b1;
        bus.i_addr  = 32'h300;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h2000;
        bus.d_wdata = 32'hDEADBEEF;
        bus.d_be    = 4'hF;
        settle();
        check("sim_d_gnt", bus.d_gnt, 1);
        check("sim_i_gnt", bus.i_gnt, 0);
        next_cycle();
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        settle();
        check("sim_m_we", bus.m_we, 1);
        check("sim_m_addr", bus.m_addr, 32'h2000);
        check("sim_m_wdata", bus.m_wdata, 32'hDEADBEEF);
        check("sim_busy_i_gnt", bus.i_gnt, 0);
        next_cycle();
        bus.m_ack   = 1'b1;
        bus.m_rdata = 32'h55;
        settle();
        check("sim_m_we_hold", bus.m_we, 1);
        next_cycle();
        bus.m_ack = 1'b0;
        settle();
        check("sim_d_rvalid", bus.d_rvalid, 1);
        check("sim_d_rdata", bus.d_rdata, 0);
        check("sim_then_i_gnt", bus.i_gnt, 1);
        next_cycle();
        bus.i_req   = 1'b0;
        bus.m_ack   = 1'b1;
        bus.m_rdata = 32'h77;
        settle();
        check("sim_i_m_addr", bus.m_addr, 32'h300);
        check("sim_i_m_we", bus.m_we, 0);
        next_cycle();
        bus.m_ack = 1'b0;
        settle();
        check("sim_i_rdata", bus.i_rdata, 32'h77);

        // Starvation bound, ack latency 1
        do_reset();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h40;
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h80;
        ng = 0;
        for (int c = 0; c < 30; c++) begin
            settle();
            if (ng < 10 && (bus.i_gnt || bus.d_gnt)) begin
                order[ng] = bus.i_gnt ? "I" : "D";
                ng++;
            end
            bus.m_ack = bus.m_req;
            next_cycle();
        end
        idle_inputs();
        check("order_count", ng, 10);
        for (int k = 0; k < ng; k++)
            check($sformatf("order%0d", k), order[k],
                  (k % 5 == 4) ? "I" : "D");

        // Wait states
        do_reset();
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h4444;
        settle();
        check("ws_d_gnt", bus.d_gnt, 1);
        next_cycle();
        bus.d_req = 1'b0;
        bus.i_req = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            settle();
            check($sformatf("ws_m_req%0d", c), bus.m_req, 1);
            check($sformatf("ws_m_addr%0d", c), bus.m_addr, 32'h4444);
            check($sformatf("ws_gnt%0d", c), bus.i_gnt | bus.d_gnt, 0);
            check($sformatf("ws_rv%0d", c), bus.d_rvalid, 0);
            bus.m_ack   = (c == 5);
            bus.m_rdata = 32'hCAFE0001;
            next_cycle();
        end
        bus.m_ack = 1'b0;
        bus.i_req = 1'b0;
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            settle();
            if (c == 0)
                check("ws_rdata", bus.d_rdata, 32'hCAFE0001);
            cnt += int'(bus.d_rvalid);
            next_cycle();
        end
        check("ws_rv_count", cnt, 1);

        // Reset mid-access
        do_reset();
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h88;
        settle();
        check("rm_d_gnt", bus.d_gnt, 1);
        next_cycle();
        bus.d_req = 1'b0;
        settle();
        check("rm_m_req", bus.m_req, 1);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst         = 1'b0;
        bus.m_ack   = 1'b1;
        bus.m_rdata = 32'h99;
        settle();
        check("rm_m_req_off", bus.m_req, 0);
        check("rm_no_rv", bus.d_rvalid, 0);
        next_cycle();
        bus.m_ack = 1'b0;
        settle();
        check("rm_no_late_rv", bus.d_rvalid, 0);
        check("rm_rdata", bus.d_rdata, 0);
        bus.d_req = 1'b1;
        settle();
        check("rm_idle_gnt", bus.d_gnt, 1);
        next_cycle();

        // Hung access
        do_reset();
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h1230;
        settle();
        check("to_pre_gnt", bus.d_gnt, 1);
        next_cycle();
        bus.d_req   = 1'b0;
        bus.m_ack   = 1'b1;
        bus.m_rdata = 32'hABCD;
        next_cycle();
        bus.m_ack  = 1'b0;
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h1234;
        settle();
        check("to_pre_rdata", bus.d_rdata, 32'hABCD);
        check("to_gnt", bus.d_gnt, 1);
        next_cycle();
        bus.d_req = 1'b0;
        for (int b = 1; b <= TMO; b++) begin
            settle();
            check($sformatf("to_m_req%0d", b), bus.m_req, 1);
            next_cycle();
        end
        settle();
`ifdef MEM_ARB_TIMEOUT_EN
        check("to_m_req_off", bus.m_req, 0);
        check("to_d_rvalid", bus.d_rvalid, 1);
        check("to_d_err", bus.d_err, 1);
        check("to_d_rdata", bus.d_rdata, 0);
`else
        check("to_m_req_on", bus.m_req, 1);
        check("to_no_rv", bus.d_rvalid, 0);
        check("to_rdata_hold", bus.d_rdata, 32'hABCD);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            cnt += int'(bus.m_req);
            next_cycle();
        end
        check("to_m_req_held", cnt, 20);
`endif

        // Randomized run against the model
        do_reset();
        busy = 0; burst = 0; bcyc = 0; win_prev = 0;
        exp_irv = 0; exp_drv = 0; exp_ierr = 0; exp_derr = 0;
        last_ird = '0; last_drd = '0;
        cur_we = 0; cur_addr = '0; cur_wdata = '0; cur_be = '0;
        for (int c = 0; c < 800; c++) begin
            // A pending request is normally held until granted.
            if (!(bus.i_req && win_prev != 1 && $urandom_range(15) != 0)) begin
                bus.i_req  = ($urandom_range(2) != 0);
                bus.i_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!(bus.d_req && win_prev != 2 && $urandom_range(15) != 0)) begin
                bus.d_req   = ($urandom_range(2) != 0);
                bus.d_we    = $urandom_range(1) != 0;
                bus.d_addr  = $urandom & 32'hFFFF_FFFC;
                bus.d_wdata = $urandom;
                bus.d_be    = 4'($urandom_range(15));
            end
            bus.m_ack   = (busy != 0) ? ($urandom_range(2) == 0)
                                      : ($urandom_range(7) == 0);
            bus.m_rdata = $urandom;
            settle();

            check("rnd_i_rvalid", bus.i_rvalid, exp_irv);
            check("rnd_d_rvalid", bus.d_rvalid, exp_drv);
            check("rnd_i_rdata", bus.i_rdata, last_ird);
            check("rnd_d_rdata", bus.d_rdata, last_drd);
            if (exp_irv) check("rnd_i_err", bus.i_err, exp_ierr);
            if (exp_drv) check("rnd_d_err", bus.d_err, exp_derr);

            win = 0;
            if (busy == 0) begin
                if (bus.d_req && !(bus.i_req && burst >= MAXB)) win = 2;
                else if (bus.i_req) win = 1;
            end
            check("rnd_i_gnt", bus.i_gnt, win == 1);
            check("rnd_d_gnt", bus.d_gnt, win == 2);
            check("rnd_m_req", bus.m_req, busy != 0);
            if (busy != 0) begin
                check("rnd_m_addr", bus.m_addr, cur_addr);
                check("rnd_m_we", bus.m_we, cur_we);
                check("rnd_m_be", bus.m_be, cur_be);
                if (cur_we) check("rnd_m_wdata", bus.m_wdata, cur_wdata);
            end

            exp_irv = 0;
            exp_drv = 0;
            if (busy != 0) begin
                if (bus.m_ack) begin
                    rd = cur_we ? 32'h0 : bus.m_rdata;
                    if (busy == 1) begin
                        exp_irv = 1; last_ird = rd; exp_ierr = 0;
                    end else begin
                        exp_drv = 1; last_drd = rd; exp_derr = 0;
                    end
                    busy = 0;
                end else begin
                    bcyc++;
`ifdef MEM_ARB_TIMEOUT_EN
                    if (bcyc == TMO) begin
                        if (busy == 1) begin
                            exp_irv = 1; last_ird = '0; exp_ierr = 1;
                        end else begin
                            exp_drv = 1; last_drd = '0; exp_derr = 1;
                        end
                        busy = 0;
                    end
`endif
                end
            end else if (win == 2) begin
                cur_we    = bus.d_we;
                cur_addr  = bus.d_addr;
                cur_wdata = bus.d_wdata;
                cur_be    = bus.d_be;
                busy      = 2;
                bcyc      = 0;
                burst     = bus.i_req ? ((burst < MAXB) ? burst + 1 : MAXB) : 0;
            end else if (win == 1) begin
                cur_we   = 0;
                cur_addr = bus.i_addr;
                cur_be   = 4'hF;
                busy     = 1;
                bcyc     = 0;
                burst    = 0;
            end
            win_prev = win;
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
